ez8_loader: RTL

- Boot/debug controller for the ez8 CPU.
- Accepts a byte stream from a host link (UART receiver or JTAG bridge) using a valid/ready handshake.
- Decodes simple commands; assembles 16-bit instruction words and drives the CPU's instruction-memory write port.
- Sequences the CPU's reset and pause inputs so a program can be loaded, started, halted and restarted without a full-chip reset.

---
 rtl/ez8_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ez8_loader.sv
// ez8_loader: boot/debug controller that loads programs into ez8 instruction memory
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   in_data         host command/data byte
//   in_valid        in_data valid
//   in_ready        byte accepted when in_valid && in_ready at a rising clk edge
//   cpu_reset       drives CPU reset
//   cpu_pause       drives CPU pause
//   cpu_stopped     CPU stopped flag (status only)
//   instr_writeaddr instruction write address
//   instr_writedata instruction word
//   instr_write_en  one-cycle write strobe
//   busy            high in any state other than IDLE
//   load_done       one-cycle pulse when a LOAD completes
//   load_count      number of words written by the last LOAD
//   load_error      sticky checksum error
//   running         !cpu_pause && !cpu_reset && !cpu_stopped
//
// Optional feature: define EZ8_LOADER_CHECKSUM_EN to add a trailing checksum
// byte (mod-256 sum of data bytes) to every LOAD. Without it, load_error stays 0.
module ez8_loader #(
    parameter int ADDR_WIDTH   = 12,
    parameter int RESET_CYCLES = 4,
    parameter int BOOT_RUN     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cpu_reset,
    output logic                  cpu_pause,
    input  logic                  cpu_stopped,
    output logic [ADDR_WIDTH-1:0] instr_writeaddr,
    output logic [15:0]           instr_writedata,
    output logic                  instr_write_en,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH-1:0] load_count,
    output logic                  load_error,
    output logic                  running
);

    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, RSTP} state_t;

`ifdef EZ8_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    // state entered once all words are written (or count was zero)
    localparam state_t DONE = CHK_EN ? CHK : IDLE;

    state_t                state, state_d;
    logic [11:0]           count, count_d, words, words_d, cnt_new;
    logic [7:0]            hi, hi_d, rst_cnt, rst_cnt_d, sum, sum_d;
    logic                  cpu_reset_d, cpu_pause_d, write_en_d, load_done_d, load_error_d;
    logic [ADDR_WIDTH-1:0] waddr_d, load_count_d;
    logic [15:0]           wdata_d;
    logic                  acc, last;

    assign in_ready = state != RSTP;
    assign busy     = state != IDLE;
    assign running  = !cpu_pause && !cpu_reset && !cpu_stopped;
    assign acc      = in_valid && in_ready;
    assign cnt_new  = {count[11:8], in_data};
    assign last     = words + 12'd1 == count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cpu_reset       <= 1'b0;
            cpu_pause       <= BOOT_RUN == 0;
            instr_write_en  <= 1'b0;
            instr_writeaddr <= '0;
            instr_writedata <= '0;
            load_done       <= 1'b0;
            load_count      <= '0;
            load_error      <= 1'b0;
            count           <= '0;
            words           <= '0;
            hi              <= '0;
            rst_cnt         <= '0;
            sum             <= '0;
        end else begin
            state           <= state_d;
            cpu_reset       <= cpu_reset_d;
            cpu_pause       <= cpu_pause_d;
            instr_write_en  <= write_en_d;
            instr_writeaddr <= waddr_d;
            instr_writedata <= wdata_d;
            load_done       <= load_done_d;
            load_count      <= load_count_d;
            load_error      <= load_error_d;
            count           <= count_d;
            words           <= words_d;
            hi              <= hi_d;
            rst_cnt         <= rst_cnt_d;
            sum             <= sum_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (acc) state_d = in_data == 8'h01 ? CNT_HI : in_data == 8'h04 ? RSTP : IDLE;
            CNT_HI:  if (acc) state_d = CNT_LO;
            CNT_LO:  if (acc) state_d = cnt_new == 12'd0 ? DONE : DATA_HI;
            DATA_HI: if (acc) state_d = DATA_LO;
            DATA_LO: if (acc) state_d = last ? DONE : DATA_HI;
            CHK:     if (acc) state_d = IDLE;
            RSTP:    if (rst_cnt == 8'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_reset_d  = cpu_reset;
        cpu_pause_d  = cpu_pause;
        write_en_d   = 1'b0;
        // address advances in the cycle after each strobe
        waddr_d      = instr_write_en ? instr_writeaddr + ADDR_WIDTH'(1) : instr_writeaddr;
        wdata_d      = instr_writedata;
        load_done_d  = 1'b0;
        load_count_d = load_count;
        load_error_d = load_error;
        count_d      = count;
        words_d      = words;
        hi_d         = hi;
        rst_cnt_d    = rst_cnt;
        sum_d        = sum;
        case (state)
            IDLE: if (acc) begin
                if (in_data == 8'h01) load_error_d = 1'b0;
                if (in_data == 8'h02) cpu_pause_d = 1'b0;
                if (in_data == 8'h03) cpu_pause_d = 1'b1;
                if (in_data == 8'h04) begin
                    cpu_reset_d = 1'b1;
                    rst_cnt_d   = 8'(RESET_CYCLES);
                end
            end
            CNT_HI: if (acc) begin
                count_d     = {in_data[3:0], 8'h00};
                cpu_reset_d = 1'b1;
                cpu_pause_d = 1'b1;
                waddr_d     = '0;
                words_d     = '0;
                sum_d       = '0;
            end
            CNT_LO: if (acc) begin
                count_d = cnt_new;
                if (cnt_new == 12'd0 && !CHK_EN) begin
                    load_done_d  = 1'b1;
                    load_count_d = '0;
                    cpu_reset_d  = 1'b0;
                end
            end
            DATA_HI: if (acc) begin
                hi_d  = in_data;
                sum_d = sum + in_data;
            end
            DATA_LO: if (acc) begin
                wdata_d    = {hi, in_data};
                write_en_d = 1'b1;
                words_d    = words + 12'd1;
                sum_d      = sum + in_data;
                if (last && !CHK_EN) begin
                    load_done_d  = 1'b1;
                    load_count_d = ADDR_WIDTH'(count);
                    cpu_reset_d  = 1'b0;
                end
            end
            CHK: if (acc) begin
                load_done_d  = 1'b1;
                load_count_d = ADDR_WIDTH'(count);
                // a bad checksum keeps the CPU in reset until a clean LOAD or RESET
                cpu_reset_d  = in_data != sum;
                load_error_d = load_error || in_data != sum;
            end
            RSTP: begin
                rst_cnt_d = rst_cnt - 8'd1;
                if (rst_cnt == 8'd1) cpu_reset_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
